// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM arbiter serving instruction fetch and load/store requests
//   clk_in, rst_in (sync, active-high), rdy_in (low = freeze everything)
//   mem_din/mem_dout/mem_a/mem_wr : byte-wide RAM with one-cycle read latency
//   io_buffer_full               : blocks IO stores (addr[17:16]==2'b11)
//   if_req/if_addr/if_done/if_data: 4-byte fetch port
//   ls_req/ls_wr/ls_addr/ls_size/ls_wdata/ls_done/ls_rdata: load/store port, ls wins over if
//   flush                        : aborts reads, blocks acceptance in IDLE
module mem_ctrl (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [31:0] ls_addr,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   input  logic        flush
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
   state_t      state;
   logic [31:0] addr, wdata, acc, asm, mask, if_data_q, ls_rdata_q;
   logic [2:0]  len, ls_len;
   logic [1:0]  cnt, cap_idx, lidx;
   logic        is_ls, is_wr, fresh, cap;
   logic        io_block, can_acc, take_ls, take_if, wr_acc, last;
   assign io_block = ls_wr && ls_addr[17:16] == 2'b11 && io_buffer_full;
   assign can_acc  = state == IDLE && !flush && !if_done && !ls_done;
   assign take_ls  = ls_req && !io_block;
   assign take_if  = if_req && !take_ls;
   assign wr_acc   = take_ls && ls_wr;
   assign ls_len   = ls_size == 2'd0 ? 3'd1 : ls_size == 2'd1 ? 3'd2 : 3'd4;
   assign last     = {1'b0, cnt} == len - 3'd1;
   assign lidx     = len[1:0] - 2'd1;
   assign mask     = len == 3'd1 ? 32'h0000_00FF : len == 3'd2 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   // The final byte arrives on mem_din during the done cycle itself, so it is merged here.
   always_comb begin
      asm = acc & mask;
      asm[{lidx, 3'b000} +: 8] = mem_din;
   end
   assign if_data  = if_done ? asm : if_data_q;
   assign ls_rdata = ls_done && !is_wr ? asm : ls_rdata_q;
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state      <= IDLE;
         addr       <= '0;
         wdata      <= '0;
         acc        <= '0;
         len        <= '0;
         cnt        <= '0;
         cap_idx    <= '0;
         is_ls      <= 1'b0;
         is_wr      <= 1'b0;
         fresh      <= 1'b0;
         cap        <= 1'b0;
         mem_a      <= '0;
         mem_dout   <= '0;
         mem_wr     <= 1'b0;
         if_done    <= 1'b0;
         ls_done    <= 1'b0;
         if_data_q  <= '0;
         ls_rdata_q <= '0;
      end else begin
         // The RAM keeps clocking during a stall, so the byte for a freshly issued
         // address is captured one edge later whether or not rdy_in is high.
         if (cap) acc[{cap_idx, 3'b000} +: 8] <= mem_din;
         cap     <= fresh;
         cap_idx <= cnt;
         fresh   <= 1'b0;
         if (rdy_in) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            if (if_done) if_data_q <= asm;
            if (ls_done && !is_wr) ls_rdata_q <= asm;
            case (state)
               IDLE: if (can_acc && (take_ls || take_if)) begin
                  state    <= wr_acc ? WRITE : READ;
                  addr     <= take_ls ? ls_addr : if_addr;
                  wdata    <= ls_wdata;
                  len      <= take_ls ? ls_len : 3'd4;
                  is_ls    <= take_ls;
                  is_wr    <= wr_acc;
                  cnt      <= '0;
                  acc      <= '0;
                  fresh    <= !wr_acc;
                  mem_a    <= take_ls ? ls_addr : if_addr;
                  mem_wr   <= wr_acc;
                  mem_dout <= wr_acc ? ls_wdata[7:0] : 8'd0;
               end
               READ: if (flush) begin
                  state <= IDLE;
                  mem_a <= '0;
               end else if (last) begin
                  state   <= IDLE;
                  mem_a   <= '0;
                  if_done <= !is_ls;
                  ls_done <= is_ls;
               end else begin
                  cnt   <= cnt + 2'd1;
                  mem_a <= addr + {30'b0, cnt + 2'd1};
                  fresh <= 1'b1;
               end
               WRITE: if (last) begin
                  state    <= IDLE;
                  mem_a    <= '0;
                  mem_wr   <= 1'b0;
                  mem_dout <= '0;
                  ls_done  <= 1'b1;
               end else begin
                  cnt      <= cnt + 2'd1;
                  mem_a    <= addr + {30'b0, cnt + 2'd1};
                  mem_dout <= wdata[{cnt + 2'd1, 3'b000} +: 8];
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a one-cycle-latency byte RAM
module tb_mem_ctrl;
   logic        clk = 0, rst = 1, rdy = 1, io_full = 0, flush = 0;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a, if_addr = 0, if_data, ls_addr = 0, ls_wdata = 0, ls_rdata;
   logic        mem_wr, if_req = 0, if_done, ls_req = 0, ls_wr = 0, ls_done;
   logic [1:0]  ls_size = 0;
   logic [7:0]  ram [0:4095];
   int          nvec = 0, nerr = 0;
   mem_ctrl dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_full), .if_req(if_req),
      .if_addr(if_addr), .if_done(if_done), .if_data(if_data), .ls_req(ls_req),
      .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size), .ls_wdata(ls_wdata),
      .ls_done(ls_done), .ls_rdata(ls_rdata), .flush(flush)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
      ram[12'h020] = 8'hFF; ram[12'h021] = 8'h77;
      ram[12'h050] = 8'h11; ram[12'h051] = 8'h22;
      step(2);
      rst = 0;
      chk("rst mem_a", mem_a, 0);
      chk("rst mem_wr", {31'b0, mem_wr}, 0);
      chk("rst mem_dout", {24'b0, mem_dout}, 0);
      chk("rst dones", {30'b0, if_done, ls_done}, 0);
      chk("rst if_data", if_data, 0);
      chk("rst ls_rdata", ls_rdata, 0);
      // fetch
      if_req = 1; if_addr = 32'h100;
      step;
      if_req = 0;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("fetch mem_a c%0d", k), mem_a, 32'h100 + k - 1);
         chk($sformatf("fetch done c%0d", k), {31'b0, if_done}, 0);
         step;
      end
      chk("fetch if_done", {31'b0, if_done}, 1);
      chk("fetch if_data", if_data, 32'h0010_0513);
      chk("fetch idle mem_a", mem_a, 0);
      step;
      chk("fetch done pulse", {31'b0, if_done}, 0);
      chk("fetch data hold", if_data, 32'h0010_0513);
      // contention: byte load wins, fetch waits past the done cycle
      if_req = 1; if_addr = 32'h100;
      ls_req = 1; ls_wr = 0; ls_addr = 32'h20; ls_size = 0;
      step;
      ls_req = 0;
      chk("cont mem_a c1", mem_a, 32'h20);
      step;
      chk("cont ls_done", {31'b0, ls_done}, 1);
      chk("cont ls_rdata", ls_rdata, 32'h0000_00FF);
      chk("cont if_done", {31'b0, if_done}, 0);
      step;
      chk("cont no accept in done", mem_a, 0);
      chk("cont rdata hold", ls_rdata, 32'h0000_00FF);
      step;
      if_req = 0;
      chk("cont fetch mem_a", mem_a, 32'h100);
      step(4);
      chk("cont fetch done", {31'b0, if_done}, 1);
      chk("cont fetch data", if_data, 32'h0010_0513);
      step;
      // half-word store
      ls_req = 1; ls_wr = 1; ls_size = 1; ls_addr = 32'h40; ls_wdata = 32'hABCD_1234;
      step;
      ls_req = 0;
      chk("st c1", {mem_wr, 15'b0, mem_a[7:0], mem_dout}, {1'b1, 15'b0, 8'h40, 8'h34});
      step;
      chk("st c2", {mem_wr, 15'b0, mem_a[7:0], mem_dout}, {1'b1, 15'b0, 8'h41, 8'h12});
      step;
      chk("st c3 done", {30'b0, ls_done, mem_wr}, 32'b10);
      chk("st c3 mem_a", mem_a, 0);
      chk("st rdata hold", ls_rdata, 32'h0000_00FF);
      step;
      chk("st done pulse", {31'b0, ls_done}, 0);
      // IO store held off while the UART buffer is full
      ls_req = 1; ls_wr = 1; ls_size = 0; ls_addr = 32'h3_0000; ls_wdata = 32'h5A; io_full = 1;
      for (int i = 0; i < 10; i++) begin
         step;
         chk($sformatf("io blocked %0d", i), {31'b0, mem_wr}, 0);
      end
      io_full = 0;
      step;
      ls_req = 0;
      chk("io accept", {mem_wr, mem_a[30:0]}, {1'b1, 31'h3_0000});
      chk("io dout", {24'b0, mem_dout}, 32'h5A);
      step;
      chk("io done", {31'b0, ls_done}, 1);
      step;
      // flush in cycle 2 of a fetch
      if_req = 1; if_addr = 32'h100;
      step;
      if_req = 0;
      step;
      flush = 1;
      chk("fl c2 mem_a", mem_a, 32'h101);
      step;
      flush = 0;
      chk("fl abort mem_a", mem_a, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fl no done %0d", i), {31'b0, if_done}, 0);
         step;
      end
      chk("fl data hold", if_data, 32'h0010_0513);
      // flush in IDLE blocks acceptance
      if_req = 1; flush = 1;
      step;
      flush = 0;
      chk("fl idle blocked", mem_a, 0);
      step;
      if_req = 0;
      chk("fl idle accept", mem_a, 32'h100);
      step(4);
      chk("fl idle fetch done", {31'b0, if_done}, 1);
      step;
      // flush does not affect a word store
      ls_req = 1; ls_wr = 1; ls_size = 2; ls_addr = 32'h80; ls_wdata = 32'hCAFE_F00D;
      step;
      ls_req = 0;
      step;
      flush = 1;
      step;
      flush = 0;
      chk("flw c3", {mem_wr, 15'b0, mem_a[7:0], mem_dout}, {1'b1, 15'b0, 8'h82, 8'hFE});
      step;
      chk("flw c4 dout", {24'b0, mem_dout}, 32'hCA);
      step;
      chk("flw done", {30'b0, ls_done, mem_wr}, 32'b10);
      step;
      // 3-cycle stall in the second byte of a half-word load
      ls_req = 1; ls_wr = 0; ls_size = 1; ls_addr = 32'h50;
      step;
      ls_req = 0;
      step;
      rdy = 0;
      for (int i = 0; i < 3; i++) begin
         step;
         chk($sformatf("stall mem_a %0d", i), mem_a, 32'h51);
      end
      rdy = 1;
      chk("stall no early done", {31'b0, ls_done}, 0);
      step;
      chk("stall done", {31'b0, ls_done}, 1);
      chk("stall rdata", ls_rdata, 32'h0000_2211);
      step;
      // reset in cycle 3 of a word store, also with rdy low
      ls_req = 1; ls_wr = 1; ls_size = 2; ls_addr = 32'h60; ls_wdata = 32'h1122_3344;
      step;
      ls_req = 0;
      step(2);
      chk("rs c3", {mem_wr, 15'b0, mem_a[7:0], mem_dout}, {1'b1, 15'b0, 8'h62, 8'h22});
      rst = 1; rdy = 0;
      step;
      rst = 0; rdy = 1;
      chk("rs c4 mem_wr", {31'b0, mem_wr}, 0);
      chk("rs c4 mem_a", mem_a, 0);
      chk("rs c4 ls_done", {31'b0, ls_done}, 0);
      chk("rs c4 ls_rdata", ls_rdata, 0);
      step;
      chk("rs c5 ls_done", {31'b0, ls_done}, 0);
      chk("rs c5 mem_wr", {31'b0, mem_wr}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
